// File: rtl/jelly_rtos_wb_cmd_decoder.sv
// jelly_rtos_wb_cmd_decoder
//   Wishbone slave front end for the RTOS scheduler core. Each access address
//   {opcode, id} is decoded: opcode 0x00 (REF_CFG) and 0x01 (CPU_CTL) are
//   served locally; writes to any other opcode are forwarded to the scheduler
//   over a valid/ready command port. Also drives the task-switch interrupt.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_wb_*                Wishbone slave (adr/dat_i/dat_o/we/sel/stb/ack)
//   m_cmd_*               scheduler command port (opcode/id/data, valid/ready)
//   top_tskid/top_valid   highest-priority ready task from the scheduler
//   run_tskid/run_valid   task currently run by the CPU (CPU_CTL registers)
//   irq                   task-switch interrupt request
//
// Optional feature macro: JELLY_RTOS_CMD_TIMEOUT_EN
//   Defined: a command not accepted within 255 cycles is abandoned, acked,
//   and flagged in the sticky CPU_CTL/0x20 ERR_STS bit (write 1 to clear).

module jelly_rtos_wb_cmd_decoder #(
  parameter int unsigned WB_ADR_WIDTH = 16,
  parameter int unsigned WB_DAT_WIDTH = 32,
  parameter int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned TSKID_WIDTH  = 4,
  parameter logic [31:0] CORE_ID      = 32'h527a_0101,
  parameter logic [31:0] CORE_VERSION = 32'h0001_0000,
  parameter logic [31:0] CORE_DATE    = 32'h2020_0101
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  output logic [OPCODE_WIDTH-1:0] m_cmd_opcode,
  output logic [ID_WIDTH-1:0]     m_cmd_id,
  output logic [WB_DAT_WIDTH-1:0] m_cmd_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  input  logic [TSKID_WIDTH-1:0]  top_tskid,
  input  logic                    top_valid,
  output logic [TSKID_WIDTH-1:0]  run_tskid,
  output logic                    run_valid,
  output logic                    irq
);

  localparam logic [OPCODE_WIDTH-1:0] OP_REF_CFG = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_CPU_CTL = OPCODE_WIDTH'(1);

  localparam logic [ID_WIDTH-1:0] ID_CORE_ID      = ID_WIDTH'(8'h00);
  localparam logic [ID_WIDTH-1:0] ID_CORE_VERSION = ID_WIDTH'(8'h01);
  localparam logic [ID_WIDTH-1:0] ID_CORE_DATE    = ID_WIDTH'(8'h04);
  localparam logic [ID_WIDTH-1:0] ID_TOP_TSKID    = ID_WIDTH'(8'h00);
  localparam logic [ID_WIDTH-1:0] ID_TOP_VALID    = ID_WIDTH'(8'h01);
  localparam logic [ID_WIDTH-1:0] ID_RUN_TSKID    = ID_WIDTH'(8'h04);
  localparam logic [ID_WIDTH-1:0] ID_RUN_VALID    = ID_WIDTH'(8'h05);
  localparam logic [ID_WIDTH-1:0] ID_IRQ_EN       = ID_WIDTH'(8'h10);
  localparam logic [ID_WIDTH-1:0] ID_IRQ_STS      = ID_WIDTH'(8'h11);
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
  localparam logic [ID_WIDTH-1:0] ID_ERR_STS      = ID_WIDTH'(8'h20);
  localparam int unsigned         CNT_WIDTH       = 8;
  // Last CMD cycle index before giving up (255 cycles in CMD in total).
  localparam logic [CNT_WIDTH-1:0] CNT_LAST       = CNT_WIDTH'(254);
`endif

  typedef enum logic [1:0] {IDLE, CMD, ACK, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      ack_q, ack_d;
  logic [WB_DAT_WIDTH-1:0]   dat_q, dat_d;
  logic                      valid_q, valid_d;
  logic [OPCODE_WIDTH-1:0]   opcode_q, opcode_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [WB_DAT_WIDTH-1:0]   data_q, data_d;
  logic [TSKID_WIDTH-1:0]    run_tskid_q, run_tskid_d;
  logic                      run_valid_q, run_valid_d;
  logic                      irq_en_q, irq_en_d;
  logic                      irq_q, irq_d;
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
  logic                      err_q, err_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
`endif

  logic [OPCODE_WIDTH-1:0]   adr_opcode_c;
  logic [ID_WIDTH-1:0]       adr_id_c;
  logic [WB_DAT_WIDTH-1:0]   cfg_rdata_c;
  logic [WB_DAT_WIDTH-1:0]   ctl_rdata_c;
  logic                      irq_sts_c;
  logic                      unused_c;

  assign adr_opcode_c = s_wb_adr_i[ID_WIDTH +: OPCODE_WIDTH];
  assign adr_id_c     = s_wb_adr_i[ID_WIDTH-1:0];
  // Upper address bits and upper byte enables carry no meaning here.
  assign unused_c     = ^{s_wb_adr_i, s_wb_sel_i};

  // Interrupt status from the current register state.
  assign irq_sts_c = irq_en_q & top_valid &
                     (~run_valid_q | (top_tskid != run_tskid_q));

  // REF_CFG read mux.
  always_comb begin
    cfg_rdata_c = '0;
    case (adr_id_c)
      ID_CORE_ID:      cfg_rdata_c = WB_DAT_WIDTH'(CORE_ID);
      ID_CORE_VERSION: cfg_rdata_c = WB_DAT_WIDTH'(CORE_VERSION);
      ID_CORE_DATE:    cfg_rdata_c = WB_DAT_WIDTH'(CORE_DATE);
      default:         cfg_rdata_c = '0;
    endcase
  end

  // CPU_CTL read mux.
  always_comb begin
    ctl_rdata_c = '0;
    case (adr_id_c)
      ID_TOP_TSKID: ctl_rdata_c = WB_DAT_WIDTH'(top_tskid);
      ID_TOP_VALID: ctl_rdata_c = WB_DAT_WIDTH'(top_valid);
      ID_RUN_TSKID: ctl_rdata_c = WB_DAT_WIDTH'(run_tskid_q);
      ID_RUN_VALID: ctl_rdata_c = WB_DAT_WIDTH'(run_valid_q);
      ID_IRQ_EN:    ctl_rdata_c = WB_DAT_WIDTH'(irq_en_q);
      ID_IRQ_STS:   ctl_rdata_c = WB_DAT_WIDTH'(irq_sts_c);
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
      ID_ERR_STS:   ctl_rdata_c = WB_DAT_WIDTH'(err_q);
`endif
      default:      ctl_rdata_c = '0;
    endcase
  end

  // Access FSM, local registers and command port.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dat_d       = '0;
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    id_d        = id_q;
    data_d      = data_q;
    run_tskid_d = run_tskid_q;
    run_valid_d = run_valid_q;
    irq_en_d    = irq_en_q;
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (s_wb_stb_i) begin
          if (adr_opcode_c == OP_REF_CFG) begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (!s_wb_we_i) dat_d = cfg_rdata_c;
          end else if (adr_opcode_c == OP_CPU_CTL) begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (!s_wb_we_i) begin
              dat_d = ctl_rdata_c;
            end else if (s_wb_sel_i[0]) begin
              case (adr_id_c)
                ID_RUN_TSKID: begin
                  run_tskid_d = s_wb_dat_i[TSKID_WIDTH-1:0];
                  run_valid_d = 1'b1;
                end
                ID_RUN_VALID: run_valid_d = s_wb_dat_i[0];
                ID_IRQ_EN:    irq_en_d    = s_wb_dat_i[0];
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
                ID_ERR_STS:   if (s_wb_dat_i[0]) err_d = 1'b0;
`endif
                default: ;
              endcase
            end
          end else if (s_wb_we_i) begin
            state_d  = CMD;
            valid_d  = 1'b1;
            opcode_d = adr_opcode_c;
            id_d     = adr_id_c;
            data_d   = s_wb_dat_i;
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            // Reads of scheduler opcodes return zero and issue nothing.
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end
      end
      CMD: begin
        if (m_cmd_ready) begin
          state_d = ACK;
          valid_d = 1'b0;
          ack_d   = 1'b1;
        end
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ACK;
          valid_d = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
`else
        // Only the scheduler's ready ends a command.
`endif
      end
      ACK:     state_d = DONE;
      // Hold here until the master drops stb so an access runs once.
      DONE:    if (!s_wb_stb_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered from next-state values so a write shows on irq with the ack.
    irq_d = irq_en_d & top_valid & (~run_valid_d | (top_tskid != run_tskid_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      id_q        <= '0;
      data_q      <= '0;
      run_tskid_q <= '0;
      run_valid_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
      err_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      id_q        <= id_d;
      data_q      <= data_d;
      run_tskid_q <= run_tskid_d;
      run_valid_q <= run_valid_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign s_wb_ack_o   = ack_q;
  assign s_wb_dat_o   = dat_q;
  assign m_cmd_valid  = valid_q;
  assign m_cmd_opcode = opcode_q;
  assign m_cmd_id     = id_q;
  assign m_cmd_data   = data_q;
  assign run_tskid    = run_tskid_q;
  assign run_valid    = run_valid_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_jelly_rtos_wb_cmd_decoder.sv
// Testbench for jelly_rtos_wb_cmd_decoder: directed vector table, hand-written
// multi-cycle sequences, and random accesses against a register-level model.

module tb_jelly_rtos_wb_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_wb_adr_i;
  logic [31:0] s_wb_dat_i;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_stb_i;
  logic        s_wb_ack_o;
  logic [7:0]  m_cmd_opcode;
  logic [7:0]  m_cmd_id;
  logic [31:0] m_cmd_data;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [3:0]  top_tskid;
  logic        top_valid;
  logic [3:0]  run_tskid;
  logic        run_valid;
  logic        irq;

  always #5 clk = ~clk;

  jelly_rtos_wb_cmd_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .s_wb_adr_i   (s_wb_adr_i),
    .s_wb_dat_i   (s_wb_dat_i),
    .s_wb_dat_o   (s_wb_dat_o),
    .s_wb_we_i    (s_wb_we_i),
    .s_wb_sel_i   (s_wb_sel_i),
    .s_wb_stb_i   (s_wb_stb_i),
    .s_wb_ack_o   (s_wb_ack_o),
    .m_cmd_opcode (m_cmd_opcode),
    .m_cmd_id     (m_cmd_id),
    .m_cmd_data   (m_cmd_data),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_ready  (m_cmd_ready),
    .top_tskid    (top_tskid),
    .top_valid    (top_valid),
    .run_tskid    (run_tskid),
    .run_valid    (run_valid),
    .irq          (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Commands seen crossing the handshake: {opcode, id, data}.
  logic [47:0] cmd_q[$];

  // Model of the CPU-visible register file.
  logic [3:0] m_rt;
  logic       m_rv;
  logic       m_en;
  logic       m_err;

  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  // Handshake is visible mid-cycle; the sampling edge follows.
  always @(negedge clk) begin
    if (!reset && m_cmd_valid && m_cmd_ready)
      cmd_q.push_back({m_cmd_opcode, m_cmd_id, m_cmd_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_irq();
    return m_en && top_valid && (!m_rv || (top_tskid != m_rt));
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] adr);
    logic [7:0] op;
    logic [7:0] id;
    op = adr[15:8];
    id = adr[7:0];
    if (op == 8'h00) begin
      if (id == 8'h00) return 32'h527a_0101;
      if (id == 8'h01) return 32'h0001_0000;
      if (id == 8'h04) return 32'h2020_0101;
      return 32'h0;
    end
    if (op == 8'h01) begin
      if (id == 8'h00) return {28'h0, top_tskid};
      if (id == 8'h01) return {31'h0, top_valid};
      if (id == 8'h04) return {28'h0, m_rt};
      if (id == 8'h05) return {31'h0, m_rv};
      if (id == 8'h10) return {31'h0, m_en};
      if (id == 8'h11) return {31'h0, model_irq()};
      if (id == 8'h20) return {31'h0, m_err};
    end
    return 32'h0;
  endfunction

  task automatic model_write(input logic [15:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
    logic [7:0] id;
    id = adr[7:0];
    if (adr[15:8] == 8'h01 && sel[0]) begin
      if (id == 8'h04) begin m_rt = wdat[3:0]; m_rv = 1'b1; end
      if (id == 8'h05) m_rv = wdat[0];
      if (id == 8'h10) m_en = wdat[0];
      if (id == 8'h20 && wdat[0]) m_err = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_rt = 4'h0; m_rv = 1'b0; m_en = 1'b0; m_err = 1'b0;
  endtask

  // One Wishbone access; leaves stb low long enough for the slave to rearm.
  task automatic wb_access(input logic [15:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, input int budget,
                           output logic [31:0] rdata, output int lat, output logic irq_ack);
    bit got;
    got = 1'b0; lat = 0; rdata = '0; irq_ack = 1'b0;
    s_wb_adr_i = adr; s_wb_we_i = we; s_wb_dat_i = wdat; s_wb_sel_i = sel;
    s_wb_stb_i = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      lat++;
      if (s_wb_ack_o) begin
        got = 1'b1; rdata = s_wb_dat_o; irq_ack = irq;
        break;
      end
    end
    check("ack_seen", got, 1'b1);
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_single_cycle", s_wb_ack_o, 1'b0);
    @(posedge clk); #1;
  endtask

  // Access checked against the model (ready is expected high).
  task automatic do_access(input logic [15:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel);
    logic [31:0] rd, exp_rd;
    logic [47:0] c;
    int          lat;
    logic        irq_a;
    bit          is_cmd;
    is_cmd = we && (adr[15:8] > 8'h01);
    exp_rd = model_read(adr);
    wb_access(adr, we, wdat, sel, 50, rd, lat, irq_a);
    if (we) model_write(adr, wdat, sel);
    else    check($sformatf("read_%04h", adr), rd, exp_rd);
    check("ack_latency", lat, is_cmd ? 2 : 1);
    check("irq_at_ack", irq_a, model_irq());
    check("run_tskid", run_tskid, m_rt);
    check("run_valid", run_valid, m_rv);
    if (is_cmd) begin
      check("cmd_count", cmd_q.size(), 1);
      if (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        check("cmd_fields", c, {adr[15:8], adr[7:0], wdat});
      end
    end else begin
      check("cmd_count", cmd_q.size(), 0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        irq_a;
    logic [47:0] c;
    logic        bad;
    logic [7:0]  ids[8];
    logic [15:0] adr;
    logic        we;
    int          pick;

    reset = 1'b1;
    s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_we_i = 1'b0; s_wb_sel_i = '0; s_wb_stb_i = 1'b0;
    m_cmd_ready = 1'b1;
    top_tskid = 4'h5; top_valid = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    check("rst_ack", s_wb_ack_o, 1'b0);
    check("rst_dat", s_wb_dat_o, 32'h0);
    check("rst_valid", m_cmd_valid, 1'b0);
    check("rst_cmd_fields", {m_cmd_opcode, m_cmd_id, m_cmd_data}, 48'h0);
    check("rst_run", {run_tskid, run_valid}, 5'h0);
    check("rst_irq", irq, 1'b0);

    // Directed vector table (local registers only).
    vecs[0]  = '{16'h0000, 1'b0, 32'h0,        4'hf, 32'h527a_0101};
    vecs[1]  = '{16'h0001, 1'b0, 32'h0,        4'hf, 32'h0001_0000};
    vecs[2]  = '{16'h0004, 1'b0, 32'h0,        4'hf, 32'h2020_0101};
    vecs[3]  = '{16'h0002, 1'b0, 32'h0,        4'hf, 32'h0};
    vecs[4]  = '{16'h0000, 1'b1, 32'hffff_ffff, 4'hf, 32'h0};
    vecs[5]  = '{16'h0000, 1'b0, 32'h0,        4'hf, 32'h527a_0101};
    vecs[6]  = '{16'h0104, 1'b1, 32'h3,        4'hf, 32'h0};
    vecs[7]  = '{16'h0104, 1'b0, 32'h0,        4'hf, 32'h3};
    vecs[8]  = '{16'h0105, 1'b0, 32'h0,        4'hf, 32'h1};
    vecs[9]  = '{16'h0105, 1'b1, 32'h0,        4'he, 32'h0};
    vecs[10] = '{16'h0105, 1'b0, 32'h0,        4'hf, 32'h1};
    vecs[11] = '{16'h0100, 1'b0, 32'h0,        4'hf, 32'h5};
    vecs[12] = '{16'h0101, 1'b0, 32'h0,        4'hf, 32'h1};
    vecs[13] = '{16'h0150, 1'b0, 32'h0,        4'hf, 32'h0};
    vecs[14] = '{16'h5501, 1'b0, 32'h0,        4'hf, 32'h0};
    vecs[15] = '{16'h0120, 1'b0, 32'h0,        4'hf, 32'h0};
    for (int i = 0; i < 16; i++) begin
      wb_access(vecs[i].adr, vecs[i].we, vecs[i].wdat, vecs[i].sel, 20, rd, lat, irq_a);
      check($sformatf("vec%0d_latency", i), lat, 1);
      if (vecs[i].we) model_write(vecs[i].adr, vecs[i].wdat, vecs[i].sel);
      else            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    check("vec_no_cmd", cmd_q.size(), 0);

    // IRQ path.
    do_access(16'h0104, 1'b1, 32'h0, 4'hf);
    top_tskid = 4'h1; top_valid = 1'b1;
    do_access(16'h0110, 1'b1, 32'h1, 4'hf);
    check("irq_set", irq, 1'b1);
    do_access(16'h0111, 1'b0, 32'h0, 4'hf);
    do_access(16'h0104, 1'b1, 32'h1, 4'hf);
    check("irq_clear", irq, 1'b0);
    top_tskid = 4'h2;
    @(posedge clk); #1;
    check("irq_top_change", irq, 1'b1);
    top_valid = 1'b0;
    @(posedge clk); #1;
    check("irq_top_invalid", irq, 1'b0);

    // Command held off by ready; stb held one cycle past ack.
    m_cmd_ready = 1'b0;
    s_wb_adr_i = 16'h1001; s_wb_we_i = 1'b1; s_wb_dat_i = 32'h0; s_wb_sel_i = 4'hf;
    s_wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("hold_valid", m_cmd_valid, 1'b1);
    check("hold_opcode", m_cmd_opcode, 8'h10);
    check("hold_id", m_cmd_id, 8'h01);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (!m_cmd_valid || s_wb_ack_o || m_cmd_opcode != 8'h10 || m_cmd_id != 8'h01) bad = 1'b1;
    end
    check("hold_stable", bad, 1'b0);
    m_cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_ack", s_wb_ack_o, 1'b1);
    check("hold_valid_drop", m_cmd_valid, 1'b0);
    @(posedge clk); #1;
    check("hold_ack_once", s_wb_ack_o, 1'b0);
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (s_wb_ack_o || m_cmd_valid) bad = 1'b1;
    end
    check("hold_no_repeat", bad, 1'b0);
    check("hold_cmd_count", cmd_q.size(), 1);
    if (cmd_q.size() > 0) begin
      c = cmd_q.pop_front();
      check("hold_cmd_fields", c, {8'h10, 8'h01, 32'h0});
    end

    // Command with ready already high: ack two cycles after stb.
    do_access(16'h1801, 1'b1, 32'd10, 4'hf);

    // Reset in the middle of a command.
    m_cmd_ready = 1'b0;
    s_wb_adr_i = 16'h2203; s_wb_we_i = 1'b1; s_wb_dat_i = 32'hdead_beef; s_wb_sel_i = 4'hf;
    s_wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("rstcmd_valid", m_cmd_valid, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstcmd_valid_drop", m_cmd_valid, 1'b0);
    check("rstcmd_ack", s_wb_ack_o, 1'b0);
    check("rstcmd_run_valid", run_valid, 1'b0);
    reset = 1'b0; s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    model_reset();
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (s_wb_ack_o || m_cmd_valid) bad = 1'b1;
    end
    check("rstcmd_no_ack", bad, 1'b0);
    check("rstcmd_no_cmd", cmd_q.size(), 0);

`ifdef JELLY_RTOS_CMD_TIMEOUT_EN
    // Ready stuck low: the access times out and sets the error flag.
    wb_access(16'h3001, 1'b1, 32'h5, 4'hf, 400, rd, lat, irq_a);
    check("timeout_latency", lat, 256);
    check("timeout_valid", m_cmd_valid, 1'b0);
    check("timeout_no_cmd", cmd_q.size(), 0);
    m_err = 1'b1;
    m_cmd_ready = 1'b1;
    do_access(16'h0120, 1'b0, 32'h0, 4'hf);
    do_access(16'h0120, 1'b1, 32'h1, 4'hf);
    do_access(16'h0120, 1'b0, 32'h0, 4'hf);
`else
    m_cmd_ready = 1'b1;
    do_access(16'h0120, 1'b1, 32'h1, 4'hf);
    do_access(16'h0120, 1'b0, 32'h0, 4'hf);
`endif

    // Random accesses against the model.
    ids = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h10, 8'h11, 8'h20, 8'h00};
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        top_tskid = 4'($urandom_range(0, 15));
        top_valid = 1'($urandom_range(0, 1));
      end
      ids[7] = 8'($urandom);
      pick = $urandom_range(0, 9);
      if (pick < 7) begin
        adr = {8'h01, ids[$urandom_range(0, 7)]};
        we  = 1'($urandom_range(0, 1));
      end else if (pick == 7) begin
        adr = {8'h00, 8'($urandom_range(0, 7))};
        we  = 1'($urandom_range(0, 1));
      end else begin
        adr = {8'($urandom_range(2, 255)), 8'($urandom)};
        we  = (pick == 9) || ($urandom_range(0, 1) == 1);
      end
      do_access(adr, we, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
